// File: rtl/kbd_pkg.sv
// Shared PS/2 scan-code constants and prefix-decoder types.
package kbd_pkg;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_FIRE  = 8'h29;

    // Pause is E1 plus seven more bytes that carry no key state.
    localparam logic [2:0] SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } pfx_state_t;

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PFX_E0) || (b == PFX_F0) || (b == PFX_E1);
    endfunction

endpackage

// File: rtl/kbd_prefix_fsm.sv
// PS/2 prefix tracker: E0/F0/E1 handling, Pause skip and stale-prefix watchdog.
module kbd_prefix_fsm
    import kbd_pkg::*;
#(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byteValid,
    input  logic [7:0] byteData,
    output logic       evStb,
    output logic [7:0] evCode,
    output logic       evExt,
    output logic       evBrk,
    output logic       seqError
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    pfx_state_t      state;
    pfx_state_t      nState;
    logic [2:0]      skipCnt;
    logic [2:0]      nSkip;
    logic [WD_W-1:0] wdCnt;
    logic            err;
    logic            fromIdle;

    assign evCode = byteData;

    always_comb begin
        nState   = state;
        nSkip    = skipCnt;
        evStb    = 1'b0;
        evExt    = 1'b0;
        evBrk    = 1'b0;
        err      = 1'b0;
        fromIdle = 1'b0;
        if (byteValid) begin
            unique case (state)
                ST_EXT: begin
                    if (byteData == PFX_F0) begin
                        nState = ST_EXT_BRK;
                    end else if (byteData == PFX_E1) begin
                        err      = 1'b1;
                        fromIdle = 1'b1;
                    end else if (byteData != PFX_E0) begin
                        evStb  = 1'b1;
                        evExt  = 1'b1;
                        nState = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (is_prefix(byteData)) begin
                        err      = 1'b1;
                        fromIdle = 1'b1;
                    end else begin
                        evStb  = 1'b1;
                        evBrk  = 1'b1;
                        evExt  = (state == ST_EXT_BRK);
                        nState = ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    nSkip = skipCnt - 3'd1;
                    if (skipCnt <= 3'd1) begin
                        nState = ST_IDLE;
                    end
                end
                default: fromIdle = 1'b1;
            endcase
            // A misplaced prefix byte starts a fresh sequence.
            if (fromIdle) begin
                unique case (1'b1)
                    byteData == PFX_E0: nState = ST_EXT;
                    byteData == PFX_F0: nState = ST_BRK;
                    byteData == PFX_E1: begin
                        nState = ST_SKIP;
                        nSkip  = SKIP_LEN;
                    end
                    default: begin
                        evStb  = 1'b1;
                        nState = ST_IDLE;
                    end
                endcase
            end
        end else if (state != ST_IDLE && wdCnt == WD_MAX) begin
            nState = ST_IDLE;
            err    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            skipCnt  <= '0;
            wdCnt    <= '0;
            seqError <= 1'b0;
        end else begin
            state    <= nState;
            skipCnt  <= nSkip;
            seqError <= err;
            if (byteValid || state == ST_IDLE) begin
                wdCnt <= '0;
            end else if (wdCnt != WD_MAX) begin
                wdCnt <= wdCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kbd_move_decoder.sv
// Scan-code stream to held arrow/space levels with left/right arbitration.
module kbd_move_decoder
    import kbd_pkg::*;
#(
    parameter logic [7:0] RIGHT_CODE = KEY_RIGHT,
    parameter logic [7:0] LEFT_CODE  = KEY_LEFT,
    parameter logic [7:0] FIRE_CODE  = KEY_FIRE,
    parameter int         TIMEOUT    = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byteValid,
    input  logic [7:0] byteData,
    output logic       right,
    output logic       left,
    output logic       fire,
    output logic       firePulse,
    output logic       seqError
);

    logic       evStb;
    logic [7:0] evCode;
    logic       evExt;
    logic       evBrk;

    logic rHeld, lHeld, fHeld;
    logic nR, nL, nF, nPulse;
    dir_t lastDir, nDir;

    kbd_prefix_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .byteValid(byteValid),
        .byteData (byteData),
        .evStb    (evStb),
        .evCode   (evCode),
        .evExt    (evExt),
        .evBrk    (evBrk),
        .seqError (seqError)
    );

    always_comb begin
        nR     = rHeld;
        nL     = lHeld;
        nF     = fHeld;
        nDir   = lastDir;
        nPulse = 1'b0;
        if (evStb) begin
            unique case (1'b1)
                evExt && evCode == RIGHT_CODE: begin
                    nR = !evBrk;
                    if (!evBrk) nDir = DIR_RIGHT;
                end
                evExt && evCode == LEFT_CODE: begin
                    nL = !evBrk;
                    if (!evBrk) nDir = DIR_LEFT;
                end
                !evExt && evCode == FIRE_CODE: begin
                    nF     = !evBrk;
                    nPulse = !evBrk && !fHeld;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rHeld     <= 1'b0;
            lHeld     <= 1'b0;
            fHeld     <= 1'b0;
            lastDir   <= DIR_LEFT;
            right     <= 1'b0;
            left      <= 1'b0;
            fire      <= 1'b0;
            firePulse <= 1'b0;
        end else begin
            rHeld     <= nR;
            lHeld     <= nL;
            fHeld     <= nF;
            lastDir   <= nDir;
            right     <= nR && (!nL || nDir == DIR_RIGHT);
            left      <= nL && (!nR || nDir == DIR_LEFT);
            fire      <= nF;
            firePulse <= nPulse;
        end
    end

endmodule
